// File: rtl/temporal_neq_array.sv
// rtl/temporal_neq_array.sv - multi-channel clocked race-logic not-equal gate with gamma time base
module temporal_neq_array #(
  parameter int N_CHANNELS        = 8,
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int PULSE_WIDTH       = 8,
  parameter int MODE              = 0,
  parameter int CW                = $clog2(GAMMA_CYCLE_WIDTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_CHANNELS-1:0]    a,
  input  logic [N_CHANNELS-1:0]    b,
  output logic [N_CHANNELS-1:0]    y,
  output logic [N_CHANNELS-1:0]    y_valid,
  output logic [N_CHANNELS*CW-1:0] y_time,
  output logic [CW-1:0]            gamma_count,
  output logic                     gamma_start
);

  localparam int PCW = (PULSE_WIDTH > 1) ? $clog2(PULSE_WIDTH) : 1;
  localparam logic [CW-1:0]  LAST_COUNT = CW'(GAMMA_CYCLE_WIDTH - 1);
  localparam logic [PCW-1:0] PULSE_LOAD = PCW'(PULSE_WIDTH - 1);
  localparam logic           Y_IDLE     = (MODE == 1) ? 1'b1 : 1'b0;

  localparam logic [1:0] ST_ARMED   = 2'd0;
  localparam logic [1:0] ST_B_SEEN  = 2'd1;
  localparam logic [1:0] ST_FIRED   = 2'd2;
  localparam logic [1:0] ST_BLOCKED = 2'd3;

  logic [N_CHANNELS-1:0] a_act, b_act, a_prev, b_prev, a_ev, b_ev, fire;
  logic [1:0]            state    [N_CHANNELS];
  logic [1:0]            state_nx [N_CHANNELS];
  logic [PCW-1:0]        pcnt     [N_CHANNELS];
  logic                  at_zero, at_last;

  assign at_zero     = (gamma_count == '0);
  assign at_last     = (gamma_count == LAST_COUNT);
  assign gamma_start = at_zero;

  // Inputs are normalised so that 1 always means "at active level".
  assign a_act = (MODE == 1) ? ~a : a;
  assign b_act = (MODE == 1) ? ~b : b;
  assign a_ev  = a_act & ~(a_prev & {N_CHANNELS{~at_zero}});
  assign b_ev  = b_act & ~(b_prev & {N_CHANNELS{~at_zero}});

  always_comb begin
    for (int i = 0; i < N_CHANNELS; i++) begin
      state_nx[i] = state[i];
      fire[i]     = 1'b0;
      case (state[i])
        ST_ARMED: begin
          if (a_ev[i] && b_ev[i]) begin
            state_nx[i] = ST_BLOCKED;
          end else if (a_ev[i]) begin
            state_nx[i] = ST_FIRED;
            fire[i]     = 1'b1;
          end else if (b_ev[i]) begin
            state_nx[i] = ST_B_SEEN;
          end
        end
        ST_B_SEEN: begin
          if (a_ev[i]) begin
            state_nx[i] = ST_FIRED;
            fire[i]     = 1'b1;
          end
        end
        default: state_nx[i] = state[i];
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gamma_count <= '0;
      a_prev      <= '0;
      b_prev      <= '0;
      y           <= {N_CHANNELS{Y_IDLE}};
      y_valid     <= '0;
      y_time      <= '0;
      for (int i = 0; i < N_CHANNELS; i++) begin
        state[i] <= ST_ARMED;
        pcnt[i]  <= '0;
      end
    end else begin
      gamma_count <= at_last ? '0 : gamma_count + 1'b1;
      a_prev      <= a_act;
      b_prev      <= b_act;
      // The wrap clears every channel and swallows any event seen in the last slot.
      if (at_last) begin
        y       <= {N_CHANNELS{Y_IDLE}};
        y_valid <= '0;
        y_time  <= '0;
        for (int i = 0; i < N_CHANNELS; i++) begin
          state[i] <= ST_ARMED;
          pcnt[i]  <= '0;
        end
      end else begin
        for (int i = 0; i < N_CHANNELS; i++) begin
          state[i] <= state_nx[i];
          if (fire[i]) begin
            y[i]                <= ~Y_IDLE;
            y_valid[i]          <= 1'b1;
            y_time[i*CW +: CW]  <= gamma_count;
            pcnt[i]             <= PULSE_LOAD;
          end else if (MODE == 2 && y[i]) begin
            if (pcnt[i] == '0) begin
              y[i] <= 1'b0;
            end else begin
              pcnt[i] <= pcnt[i] - 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_temporal_neq_array.sv
// tb/tb_temporal_neq_array.sv - directed bench for temporal_neq_array in rising, falling and pulse modes
module tb_temporal_neq_array;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic [3:0]  a0, b0, y0, v0, a1, b1, y1, v1, a2, b2, y2, v2;
  logic [15:0] t0, t1, t2;
  logic [3:0]  gc0, gc1, gc2;
  logic        gs0, gs1, gs2;

  int total = 0;
  int bad   = 0;

  temporal_neq_array #(.N_CHANNELS(4), .GAMMA_CYCLE_WIDTH(16), .PULSE_WIDTH(8), .MODE(0)) u0 (
    .clk(clk), .reset(reset), .a(a0), .b(b0), .y(y0), .y_valid(v0), .y_time(t0),
    .gamma_count(gc0), .gamma_start(gs0));
  temporal_neq_array #(.N_CHANNELS(4), .GAMMA_CYCLE_WIDTH(16), .PULSE_WIDTH(8), .MODE(1)) u1 (
    .clk(clk), .reset(reset), .a(a1), .b(b1), .y(y1), .y_valid(v1), .y_time(t1),
    .gamma_count(gc1), .gamma_start(gs1));
  temporal_neq_array #(.N_CHANNELS(4), .GAMMA_CYCLE_WIDTH(16), .PULSE_WIDTH(8), .MODE(2)) u2 (
    .clk(clk), .reset(reset), .a(a2), .b(b2), .y(y2), .y_valid(v2), .y_time(t2),
    .gamma_count(gc2), .gamma_start(gs2));

  always #5 clk = ~clk;

  typedef struct {
    int          cnt;
    logic [3:0]  a;
    logic [3:0]  b;
    logic [3:0]  y;
    logic [3:0]  v;
    logic [15:0] t;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_count(input int target);
    int n;
    n = 0;
    while (gc0 != 4'(target) && n < 40) begin
      step();
      n++;
    end
    chk("sync", 32'(gc0), 32'(target));
  endtask

  initial begin
    a0 = 4'h0; b0 = 4'h0; a1 = 4'hF; b1 = 4'hF; a2 = 4'h0; b2 = 4'h0;

    tbl[0] = '{0,  4'b0000, 4'b0000, 4'b0000, 4'b0000, 16'h0000};
    tbl[1] = '{2,  4'b0000, 4'b0010, 4'b0000, 4'b0000, 16'h0000};
    tbl[2] = '{3,  4'b0001, 4'b0010, 4'b0000, 4'b0000, 16'h0000};
    tbl[3] = '{4,  4'b0101, 4'b0110, 4'b0001, 4'b0001, 16'h0003};
    tbl[4] = '{5,  4'b0111, 4'b0110, 4'b0001, 4'b0001, 16'h0003};
    tbl[5] = '{6,  4'b0111, 4'b0110, 4'b0011, 4'b0011, 16'h0053};
    tbl[6] = '{7,  4'b0111, 4'b0111, 4'b0011, 4'b0011, 16'h0053};
    tbl[7] = '{8,  4'b0111, 4'b0111, 4'b0011, 4'b0011, 16'h0053};
    tbl[8] = '{15, 4'b0111, 4'b0111, 4'b0011, 4'b0011, 16'h0053};
    tbl[9] = '{0,  4'b0000, 4'b0000, 4'b0000, 4'b0000, 16'h0000};

    step();
    step();
    chk("rst_count", 32'(gc0), 32'd0);
    chk("rst_start", 32'(gs0), 32'd1);
    chk("rst_y0", 32'(y0), 32'h0);
    chk("rst_y1", 32'(y1), 32'hF);
    chk("rst_y2", 32'(y2), 32'h0);
    chk("rst_valid", 32'({v0, v1, v2}), 32'h0);
    chk("rst_time", 32'(t0 | t1 | t2), 32'h0);
    reset = 1'b0;

    // Rising mode: single fire, b-then-a fire and a tie, across one full gamma.
    for (int i = 0; i < 10; i++) begin
      wait_count(tbl[i].cnt);
      a0 = tbl[i].a;
      b0 = tbl[i].b;
      chk($sformatf("tbl%0d_y", i), 32'(y0), 32'(tbl[i].y));
      chk($sformatf("tbl%0d_valid", i), 32'(v0), 32'(tbl[i].v));
      chk($sformatf("tbl%0d_time", i), 32'(t0), 32'(tbl[i].t));
      chk($sformatf("tbl%0d_start", i), 32'(gs0), (tbl[i].cnt == 0) ? 32'd1 : 32'd0);
    end

    // Later edges ignored; an event in the last slot is dropped by the wrap.
    wait_count(3);  a0 = 4'b0001;
    wait_count(5);  a0 = 4'b0000;
    wait_count(8);  a0 = 4'b0001;
    wait_count(9);
    chk("reedge_time", 32'(t0), 32'h0003);
    chk("reedge_y", 32'(y0), 32'h1);
    wait_count(15); a0 = 4'b0011;
    chk("last_y", 32'(y0), 32'h1);
    wait_count(0);
    chk("drop_y", 32'(y0), 32'h0);
    chk("drop_valid", 32'(v0), 32'h0);
    wait_count(1);
    chk("held_at0_valid", 32'(v0), 32'h3);
    chk("held_at0_time", 32'(t0), 32'h0000);
    a0 = 4'b0000;

    // Falling mode: ch0 fires at 6, ch3 ties at 9.
    wait_count(0);
    wait_count(6);  a1 = 4'b1110;
    wait_count(7);
    chk("fall_y7", 32'(y1), 32'hE);
    chk("fall_valid7", 32'(v1), 32'h1);
    chk("fall_time7", 32'(t1), 32'h0006);
    wait_count(9);  a1 = 4'b0110; b1 = 4'b0111;
    wait_count(10);
    chk("fall_tie_y", 32'(y1), 32'hE);
    chk("fall_tie_valid", 32'(v1), 32'h1);
    wait_count(0);  a1 = 4'hF; b1 = 4'hF;
    chk("fall_wrap_y", 32'(y1), 32'hF);
    chk("fall_wrap_valid", 32'(v1), 32'h0);

    // Pulse mode: full-width pulse and one truncated by the wrap.
    wait_count(2);  a2 = 4'b0001;
    chk("pulse_y2", 32'(y2), 32'h0);
    wait_count(3);  a2 = 4'b0000;
    chk("pulse_y3", 32'(y2), 32'h1);
    wait_count(10);
    chk("pulse_y10", 32'(y2), 32'h1);
    wait_count(11);
    chk("pulse_y11", 32'(y2), 32'h0);
    chk("pulse_valid11", 32'(v2), 32'h1);
    chk("pulse_time11", 32'(t2), 32'h0002);
    wait_count(12); a2 = 4'b0010;
    wait_count(13); a2 = 4'b0000;
    chk("trunc_y13", 32'(y2), 32'h2);
    chk("trunc_valid13", 32'(v2), 32'h3);
    chk("trunc_time13", 32'(t2), 32'h00C2);
    wait_count(15);
    chk("trunc_y15", 32'(y2), 32'h2);
    wait_count(0);
    chk("trunc_wrap_y", 32'(y2), 32'h0);
    chk("trunc_wrap_valid", 32'(v2), 32'h0);

    // Reset mid-gamma after ch0 has fired.
    wait_count(4);  a0 = 4'b0001;
    wait_count(9);
    chk("prerst_time", 32'(t0), 32'h0004);
    reset = 1'b1;
    a0 = 4'b0000;
    #1;
    chk("midrst_y", 32'(y0), 32'h0);
    chk("midrst_valid", 32'(v0), 32'h0);
    chk("midrst_time", 32'(t0), 32'h0);
    chk("midrst_count", 32'(gc0), 32'd0);
    step();
    step();
    reset = 1'b0;
    chk("rel_count", 32'(gc0), 32'd0);
    chk("rel_start", 32'(gs0), 32'd1);
    wait_count(2);  a0 = 4'b0001;
    wait_count(3);
    chk("rel_y", 32'(y0), 32'h1);
    chk("rel_time", 32'(t0), 32'h0002);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/temporal_neq_array.md
Name: temporal_neq_array

Overview:
- Clocked, multi-channel successor to the single-channel asynchronous temporal not-equal gate.
- Each channel applies the race-logic not-equal function within a gamma cycle: output event time = a's event time if a ≠ b, otherwise no event (∞).
- Owns the gamma-cycle time base.
- Event encoding (rising, falling or pulse) is a parameter; every output is registered and timestamped.
- Sits between spike-encoding front ends and downstream temporal neuron/WTA stages.

Parameters:
- N_CHANNELS, 8, number of independent a/b/y channels.
- GAMMA_CYCLE_WIDTH, 16, clock cycles per gamma cycle (≥2); counter width CW = $clog2(GAMMA_CYCLE_WIDTH).
- PULSE_WIDTH, 8, output pulse length in cycles for MODE=2 (≥1).
- MODE, 0, event encoding:
  - 0 = rising: idle 0, event is 0→1.
  - 1 = falling: idle 1, event is 1→0.
  - 2 = pulse: idle 0, event is the leading edge of a high pulse.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- a  input  N_CHANNELS  per-channel primary temporal input (synchronous to clk).
- b  input  N_CHANNELS  per-channel inhibiting/comparison input.
- y  output  N_CHANNELS  per-channel temporal output, encoded per MODE.
- y_valid  output  N_CHANNELS  high from output event until gamma wrap.
- y_time  output  N_CHANNELS*CW  packed per-channel event timestamp; channel i occupies bits [i*CW +: CW].
- gamma_count  output  CW  current position in the gamma cycle.
- gamma_start  output  1  high while gamma_count==0.

Behaviour:
- Reset (async assert): gamma_count=0; all channels ARMED; y = idle level (all 0 for MODE 0/2, all 1 for MODE 1); y_valid=0; y_time=0; pulse counters=0; previous-sample registers = inactive level.
- Gamma counter:
  - Increments every clk from 0 to GAMMA_CYCLE_WIDTH-1, then wraps to 0.
  - gamma_start is combinational on gamma_count==0.
- Event detection, per input:
  - An event occurs in the cycle where the input is at its active level and the previous sample was inactive.
  - The previous sample is forced to inactive when gamma_count==0, so an input already active at count 0 registers an event at time 0.
  - Only the first a event and the first b event per gamma cycle are significant; later edges are ignored.
- Per-channel FSM (ARMED, B_SEEN, FIRED, BLOCKED); transitions take effect on the clock edge ending the detection cycle.
  - ARMED: a event only → FIRED. a and b events in the same cycle → BLOCKED (tie = equal times). b event only → B_SEEN.
  - B_SEEN: a event → FIRED; b events ignored.
  - FIRED and BLOCKED hold until wrap.
- Output, 1-cycle latency. For an a event detected at gamma_count=k that causes the FIRED transition, at count k+1:
  - y leaves its idle level;
  - y_valid=1;
  - y_time[ch]=k.
- Output shape by mode:
  - MODE 0/1: y holds its active level until wrap.
  - MODE 2: y is high for PULSE_WIDTH cycles, or until wrap, whichever comes first.
- BLOCKED: y stays idle, y_valid=0, y_time unchanged from its cleared value.
- Wrap edge (count GAMMA_CYCLE_WIDTH-1 → 0), all channels at once:
  - state → ARMED; y → idle level; y_valid → 0; y_time → 0; pulse counters → 0.
  - An event detected at count GAMMA_CYCLE_WIDTH-1 is dropped: the wrap has priority.
- Channels are fully independent; any combination of simultaneous events across channels is legal.
- Reset mid-gamma: outputs return to reset values immediately; the gamma cycle restarts at count 0 on release.

Test Plan:
1. MODE=0, N=4, GW=16: ch0 a rises at count 3, b at 7 → y[0] rises at count 4, y_valid[0]=1, y_time[0]=3, held through count 15, y[0]=0 at next count 0.
2. MODE=0: ch1 b at 2, a at 5 → y[1] rises at 6, y_time=5. In the same gamma, ch2 a and b both rise at 4 → y[2]=0 and y_valid[2]=0 for the whole gamma.
3. MODE=1: all inputs idle 1; ch0 a falls at 6, b never falls → y[0] falls at 7, y_time=6. Tie on ch3 at 9 → y[3] stays 1.
4. MODE=2, PULSE_WIDTH=8: ch0 a pulse at 2 → y[0] high for counts 3..10. ch1 a pulse at 12 → y[1] high for counts 13..15, truncated at wrap.
5. MODE=0: ch0 a rises at 3, falls at 5, rises at 8 → y_time stays 3. ch1 a rises at 15 → no output in that gamma, and count 0 of the next gamma shows y[1]=0 and y_valid[1]=0.
6. Assert reset at count 9 after ch0 has fired → y, y_valid and y_time clear immediately. After release: gamma_count=0, gamma_start=1, and a fresh a event at 2 produces y_time=2.
